// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, arbiter FSM states and width default
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result by op code plus operand equality
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic [3:0]       i_ctrl,
    output logic [WIDTH-1:0] o_result,
    output logic             o_eq
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] w_shamt;
    logic           w_slt;
    logic           w_sltu;

    assign w_shamt = i_op2[SHW-1:0];
    assign w_slt   = $signed(i_op1) < $signed(i_op2);
    assign w_sltu  = i_op1 < i_op2;
    assign o_eq    = (i_op1 == i_op2);

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            ALU_ADD:  o_result = i_op1 + i_op2;
            ALU_SUB:  o_result = i_op1 - i_op2;
            ALU_SLL:  o_result = i_op1 << w_shamt;
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_sltu};
            ALU_XOR:  o_result = i_op1 ^ i_op2;
            ALU_SRL:  o_result = i_op1 >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_op1) >>> w_shamt);
            ALU_OR:   o_result = i_op1 | i_op2;
            ALU_AND:  o_result = i_op1 & i_op2;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end to one shared ALU
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [3:0]       req1_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_eq
);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_owner;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_result;
    logic             r_eq;

    logic             w_any_valid;
    logic             w_grant;
    logic             w_owner_ready;
    logic             w_can_accept;
    logic             w_accept;
    logic [WIDTH-1:0] w_op1;
    logic [WIDTH-1:0] w_op2;
    logic [3:0]       w_ctrl;
    logic [WIDTH-1:0] w_result;
    logic             w_eq;

    // On a tie the requester that did not win last time gets the ALU.
    assign w_any_valid   = req0_valid | req1_valid;
    assign w_grant       = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;
    assign w_accept      = w_can_accept & w_any_valid;

    assign w_op1  = w_grant ? req1_op1  : req0_op1;
    assign w_op2  = w_grant ? req1_op2  : req0_op2;
    assign w_ctrl = w_grant ? req1_ctrl : req0_ctrl;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .i_op1    (w_op1),
        .i_op2    (w_op2),
        .i_ctrl   (w_ctrl),
        .o_result (w_result),
        .o_eq     (w_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new op may be taken in RESP only in the cycle the owner drains its result.
    always_comb begin
        w_state_nxt  = r_state;
        w_can_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_can_accept = 1'b1;
                if (w_any_valid) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_can_accept = w_owner_ready;
                if (w_owner_ready && !w_any_valid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result     <= '0;
            r_eq         <= 1'b0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_result     <= w_result;
            r_eq         <= w_eq;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
        end
    end

    assign req0_ready = rst_n & w_can_accept & w_any_valid & ~w_grant;
    assign req1_ready = rst_n & w_can_accept & w_any_valid &  w_grant;
    assign rsp0_valid = (r_state == ST_RESP) & ~r_owner;
    assign rsp1_valid = (r_state == ST_RESP) &  r_owner;
    assign rsp_result = r_result;
    assign rsp_eq     = r_eq;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_eq;

    int n_cmp;
    int n_err;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op1   (req0_op1),
        .req0_op2   (req0_op2),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op1   (req1_op1),
        .req1_op2   (req1_op2),
        .req1_ctrl  (req1_ctrl),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_eq     (rsp_eq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] t_op1 [13] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'hAAAA5555,
                                32'h0F0F0000, 32'hF0F0F0F0, 32'h00000007, 32'h12345678,
                                32'h00000001};
    logic [31:0] t_op2 [13] = '{32'h00000001, 32'h00000001, 32'h00000004, 32'h00000004,
                                32'h00000021, 32'h00000001, 32'h00000001, 32'hFFFF0000,
                                32'h00000F0F, 32'hFF00FF00, 32'h00000007, 32'h00000001,
                                32'hFFFFFFFF};
    logic [3:0]  t_ctrl [13] = '{4'b0011, 4'b0100, 4'b0111, 4'b0110, 4'b0010, 4'b0000,
                                 4'b0001, 4'b0101, 4'b1000, 4'b1001, 4'b1011, 4'b1111,
                                 4'b0011};
    logic [31:0] t_res [13]  = '{32'h00000001, 32'h00000000, 32'hF8000000, 32'h08000000,
                                 32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'h55555555,
                                 32'h0F0F0F0F, 32'hF000F000, 32'h00000000, 32'h00000000,
                                 32'h00000000};
    logic        t_eq [13]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op1 = 32'd1; req0_op2 = 32'd1; req0_ctrl = 4'b0000;
        req1_op1 = 32'd2; req1_op2 = 32'd2; req1_ctrl = 4'b0000;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step(); step();
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp0_valid got %b want 0", rsp0_valid); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp1_valid got %b want 0", rsp1_valid); end
        n_cmp++; if (rsp_result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", rsp_result); end
        n_cmp++; if (rsp_eq !== 1'b0) begin n_err++; $display("FAIL reset_eq got %b want 0", rsp_eq); end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %b want 00", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_sub();
        req0_valid = 1'b1; req0_op1 = 32'd5; req0_op2 = 32'd3; req0_ctrl = 4'b0001;
        rsp0_ready = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL sub_req0_ready got %b want 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        #1;
        n_cmp++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL sub_rsp0_valid got %b want 1", rsp0_valid); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL sub_rsp1_valid got %b want 0", rsp1_valid); end
        n_cmp++; if (rsp_result !== 32'd2) begin n_err++; $display("FAIL sub_result got %h want 2", rsp_result); end
        n_cmp++; if (rsp_eq !== 1'b0) begin n_err++; $display("FAIL sub_eq got %b want 0", rsp_eq); end
        step();
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL sub_drain got %b want 0", rsp0_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd1; req0_ctrl = 4'b0000;
        req1_valid = 1'b1; req1_op1 = 32'd20; req1_op2 = 32'd2; req1_ctrl = 4'b0000;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rr_first_grant got %b want 10", {req0_ready, req1_ready}); end
        step();
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if ({rsp1_valid, rsp0_valid} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL rr_owner_%0d got %b", k, {rsp1_valid, rsp0_valid}); end
            n_cmp++; if (rsp_result !== ((k % 2 == 0) ? 32'd11 : 32'd22)) begin
                n_err++; $display("FAIL rr_result_%0d got %h", k, rsp_result); end
            n_cmp++; if ({req1_ready, req0_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL rr_next_grant_%0d got %b", k, {req1_ready, req0_ready}); end
            if (k == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            step();
        end
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_err++; $display("FAIL rr_idle got %b want 00", {rsp1_valid, rsp0_valid}); end
    endtask

    task automatic test_ops();
        rsp0_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            req0_valid = 1'b1; req0_op1 = t_op1[i]; req0_op2 = t_op2[i]; req0_ctrl = t_ctrl[i];
            step();
            req0_valid = 1'b0;
            #1;
            n_cmp++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL op%0d_valid got %b want 1", i, rsp0_valid); end
            n_cmp++; if (rsp_result !== t_res[i]) begin n_err++; $display("FAIL op%0d_result got %h want %h", i, rsp_result, t_res[i]); end
            n_cmp++; if (rsp_eq !== t_eq[i]) begin n_err++; $display("FAIL op%0d_eq got %b want %b", i, rsp_eq, t_eq[i]); end
            step();
        end
    endtask

    task automatic test_stall();
        req0_valid = 1'b1; req0_op1 = 32'h0000F0F0; req0_op2 = 32'h0000FF00; req0_ctrl = 4'b1001;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step();
        req1_valid = 1'b1; req1_op1 = 32'd2; req1_op2 = 32'd3; req1_ctrl = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            rsp1_ready = (k % 2 == 0);
            #1;
            n_cmp++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL stall%0d_valid got %b want 1", k, rsp0_valid); end
            n_cmp++; if (rsp_result !== 32'h0000F000) begin n_err++; $display("FAIL stall%0d_result got %h want 0000f000", k, rsp_result); end
            n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL stall%0d_ready got %b want 00", k, {req0_ready, req1_ready}); end
            step();
        end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL stall_release_ready got %b want 01", {req0_ready, req1_ready}); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b10) begin n_err++; $display("FAIL stall_b2b_owner got %b want 10", {rsp1_valid, rsp0_valid}); end
        n_cmp++; if (rsp_result !== 32'd5) begin n_err++; $display("FAIL stall_b2b_result got %h want 5", rsp_result); end
        step();
    endtask

    task automatic test_valid_drop();
        req0_valid = 1'b1; req0_op1 = 32'd9; req0_op2 = 32'd9; req0_ctrl = 4'b0000;
        #2;
        req0_valid = 1'b0;
        step();
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_err++; $display("FAIL drop_no_resp got %b want 00", {rsp1_valid, rsp0_valid}); end
    endtask

    task automatic test_reset_in_resp();
        req1_valid = 1'b1; req1_op1 = 32'h000000FF; req1_op2 = 32'h0000000F; req1_ctrl = 4'b0101;
        rsp1_ready = 1'b0;
        step();
        req1_valid = 1'b0;
        #1;
        n_cmp++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'h000000F0) begin
            n_err++; $display("FAIL rir_pending got %b/%h want 1/000000f0", rsp1_valid, rsp_result); end
        req0_valid = 1'b1; req0_op1 = 32'h0000000F; req0_op2 = 32'h000000F0; req0_ctrl = 4'b1000;
        req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL rir_async_valid got %b want 0", rsp1_valid); end
        n_cmp++; if (rsp_result !== 32'd0) begin n_err++; $display("FAIL rir_async_result got %h want 0", rsp_result); end
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL rir_ready_in_reset got %b want 00", {req0_ready, req1_ready}); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rir_tie_grant got %b want 10", {req0_ready, req1_ready}); end
        rsp0_ready = 1'b1;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'h000000FF) begin
            n_err++; $display("FAIL rir_first_op got %b/%h want 1/000000ff", rsp0_valid, rsp_result); end
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_sub();
        test_round_robin();
        test_ops();
        test_stall();
        test_valid_drop();
        test_reset_in_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; shift amount SHALL use op2[$clog2(WIDTH)-1:0].
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  operation accepted this cycle when valid&ready.
REQ-006 req0_op1, req0_op2 / req1_op1, req1_op2  input  WIDTH  operands.
REQ-007 req0_ctrl / req1_ctrl  input  4  operation code, alu_pkg encoding.
REQ-008 rsp0_valid / rsp1_valid  output  1  result for that requester is held on rsp_result/rsp_eq.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester consumes its response.
REQ-010 rsp_result  output  WIDTH  registered ALU result; rsp_eq  output  1  registered (op1==op2).

Function
REQ-011 Op codes SHALL be: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed, full width), 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA (sign-filling), 1000 OR, 1001 AND; 1010-1111 SHALL yield result 0.
REQ-012 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT/SLTU SHALL yield 1 or 0 zero-extended.
REQ-013 FSM states SHALL be IDLE and RESP; exactly one operation in flight.
REQ-014 IDLE: req_ready asserted to the granted requester only; on accept, result, eq and owner id SHALL be registered and state -> RESP.
REQ-015 RESP: rspN_valid=1 only for owner N; result/eq SHALL stay stable until rspN_valid&rspN_ready.
REQ-016 RESP with owner handshake: state -> IDLE unless a new request is accepted the same cycle (back-to-back), in which case stay RESP with new result/owner.
REQ-017 In RESP, req_ready SHALL equal owner's rsp_ready gated by grant (combinational path permitted); otherwise 0.
REQ-018 Latency: accept on edge N -> rsp valid in cycle after edge N; sustained throughput one op per cycle when rsp_ready held high.
REQ-019 Arbitration round-robin: single valid requester is granted; both valid -> requester not granted last; last_grant updates only on accept.
REQ-020 Non-owner rsp_ready SHALL be ignored; req_valid deassertion before accept SHALL be legal and cause no state change.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, rsp0/1_valid 0, rsp_result 0, rsp_eq 0, last_grant=1 (req0 wins first tie).
REQ-022 Reset during RESP SHALL discard the pending response; req_ready outputs SHALL be 0 while rst_n low.

Structure
REQ-023 alu_pkg SHALL hold the op-code enum (alu_op_e), the FSM state enum and WIDTH default constant.
REQ-024 Combinational compute SHALL be a sub-module alu_core (op1, op2, ctrl -> result, eq), instanced once and fed by the granted requester's mux.

Verification
REQ-025 Req0 only, op1=5, op2=3, ctrl=0001, rsp0_ready=1 -> rsp0_valid next cycle, rsp_result=2, rsp_eq=0, rsp1_valid=0.
REQ-026 Both valid every cycle, rsp ready high -> grants alternate 0,1,0,1 starting with req0; one response per cycle.
REQ-027 SLT op1=0xFFFFFFFF, op2=1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-028 rsp0_ready low 3 cycles -> rsp0_valid and rsp_result stable, req0/req1_ready 0; rsp1_ready toggling has no effect.
REQ-029 rst_n pulled low in RESP -> rsp_valid 0 asynchronously, next op after release granted to req0 on tie.
REQ-030 ctrl=1011, op1=op2=7 -> rsp_result=0, rsp_eq=1.
